param_seq_det: RTL and testbench



---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/sat_counter.sv | 45 ++++
 rtl/param_seq_det.sv | 116 +++++++++++
 tb/tb_param_seq_det.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared defaults, helper function and mode enum for the
//               parametrised serial sequence detector (param_seq_det).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Default pattern: the original fixed 5-bit detector's sync word.
  localparam int                         SEQ_DET_DEF_LEN = 5;
  localparam logic [SEQ_DET_DEF_LEN-1:0] SEQ_DET_DEF_PAT = 5'b10010;

  // Overlap mode as driven on overlap_en.
  typedef enum logic {
    NOVL = 1'b0,
    OVL  = 1'b1
  } seq_det_mode_e;

  // The fill counter must represent 0..len inclusive.
  function automatic int seq_det_fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones. A synchronous clear
//               has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] c_cnt_max = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/param_seq_det.sv
`default_nettype none
// ============================================================================
// Module      : param_seq_det
// Description : Parametrised serial bit-pattern detector. Valid-qualified
//               input, runtime overlap selection, synchronous clear,
//               registered one-cycle match pulse.
//               Build option SEQ_DET_CNT_EN: when defined, match_cnt is a
//               saturating count of matches; when undefined it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module param_seq_det
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = SEQ_DET_DEF_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SEQ_DET_DEF_PAT,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             sync_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = seq_det_fill_w(PAT_LEN);

  // A match is possible once PAT_LEN-1 bits are already held, since the
  // incoming bit supplies the last one.
  localparam logic [FILL_W-1:0] c_fill_thr = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_LEN);

  // Elaboration-time guard on parameter ranges.
  if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_pat_len
    $error("param_seq_det: PAT_LEN must be in 2..32");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("param_seq_det: CNT_W must be in 1..32");
  end

  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] hist_d;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic               out_q;
  logic               out_d;

  logic [PAT_LEN-1:0] w_cand;
  logic               w_match;

  // History as it would look after shifting in the current bit.
  assign w_cand = {hist_q[PAT_LEN-2:0], in_bit};

  // Fill gating keeps the reset/stale contents of hist from matching.
  assign w_match = in_valid && (fill_q >= c_fill_thr) && (w_cand == PATTERN);

  // Next-state for history, fill and the match pulse.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    if (sync_clr) begin
      // Discard the current bit; hist is left alone because fill gates it.
      fill_d = '0;
    end else begin
      out_d = w_match;
      if (in_valid) begin
        hist_d = w_cand;
        if (w_match && !overlap_en) begin
          // Non-overlapping: the next match needs a full fresh pattern.
          fill_d = '0;
        end else if (fill_q != c_fill_max) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_DET_CNT_EN
  logic w_cnt_inc;

  // A cleared edge never counts, even if the bit would have matched.
  assign w_cnt_inc = w_match && !sync_clr;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (sync_clr),
    .inc (w_cnt_inc),
    .cnt (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule : param_seq_det
`default_nettype wire

// File: tb/tb_param_seq_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_seq_det
// Description : Directed self-checking bench for param_seq_det. Three
//               instances: defaults, PAT_LEN=4/PATTERN=0000, and CNT_W=2.
//               Counter expectations follow SEQ_DET_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_seq_det;
  import seq_det_pkg::*;

`ifdef SEQ_DET_CNT_EN
  localparam int c_CNT_ON = 1;
`else
  localparam int c_CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 0: defaults
  logic       v0 = 1'b0, b0 = 1'b0, ov0 = 1'b1, clr0 = 1'b0;
  logic       out0;
  logic [7:0] cnt0;
  // Instance 1: PAT_LEN=4, PATTERN=0000
  logic       v1 = 1'b0, b1 = 1'b0, ov1 = 1'b1, clr1 = 1'b0;
  logic       out1;
  logic [7:0] cnt1;
  // Instance 2: CNT_W=2
  logic       v2 = 1'b0, b2 = 1'b0, ov2 = 1'b1, clr2 = 1'b0;
  logic       out2;
  logic [1:0] cnt2;

  int errs   = 0;
  int checks = 0;

  param_seq_det u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_bit(b0), .overlap_en(ov0),
    .sync_clr(clr0), .out(out0), .match_cnt(cnt0));

  param_seq_det #(.PAT_LEN(4), .PATTERN(4'b0000)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_bit(b1), .overlap_en(ov1),
    .sync_clr(clr1), .out(out1), .match_cnt(cnt1));

  param_seq_det #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_bit(b2), .overlap_en(ov2),
    .sync_clr(clr2), .out(out2), .match_cnt(cnt2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle #1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic b, input logic c);
    v0 = v; b0 = b; clr0 = c;
    tick();
  endtask

  initial begin
    logic [7:0]  s8;
    logic [7:0]  e8;
    logic [16:0] s17;
    logic [16:0] e17;
    int          nm;
    logic [1:0]  ecnt;

    // ---- reset state ----
    tick(); tick();
    chk("rst_out0", out0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_cnt2", cnt2, 0);
    rst = 1'b0;
    tick();

    // ---- test 1: overlap, 10010010 -> pulses after bits 5 and 8 ----
    ov0 = OVL;
    s8 = 8'b10010010;
    e8 = 8'b00001001;
    for (int i = 7; i >= 0; i--) begin
      drv0(1'b1, s8[i], 1'b0);
      chk($sformatf("ovl_out_bit%0d", 8 - i), out0, e8[i]);
    end
    chk("ovl_cnt", cnt0, 2 * c_CNT_ON);

    // Asynchronous reset clears immediately, without a clock edge.
    v0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt0", cnt0, 0);
    tick();
    rst = 1'b0;
    tick();

    // ---- test 2: non-overlap, same stream -> single pulse ----
    ov0 = NOVL;
    e8 = 8'b00001000;
    for (int i = 7; i >= 0; i--) begin
      drv0(1'b1, s8[i], 1'b0);
      chk($sformatf("novl_out_bit%0d", 8 - i), out0, e8[i]);
    end
    chk("novl_cnt", cnt0, 1 * c_CNT_ON);

    // sync_clr clears the counter
    drv0(1'b0, 1'b0, 1'b1);
    chk("clr_cnt0", cnt0, 0);
    chk("clr_out0", out0, 0);

    // ---- test 3: gap of 3 invalid cycles between bits 2 and 3 ----
    ov0 = OVL;
    drv0(1'b1, 1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      drv0(1'b0, 1'b1, 1'b0);
      chk($sformatf("gap_out%0d", g), out0, 0);
    end
    drv0(1'b1, 1'b0, 1'b0);
    chk("gap_b3", out0, 0);
    drv0(1'b1, 1'b1, 1'b0);
    chk("gap_b4", out0, 0);
    drv0(1'b1, 1'b0, 1'b0);
    chk("gap_b5", out0, 1);
    drv0(1'b0, 1'b0, 1'b0);
    chk("gap_after", out0, 0);
    chk("gap_cnt", cnt0, 1 * c_CNT_ON);
    drv0(1'b0, 1'b0, 1'b1);

    // ---- test 5a: reset mid-pattern discards progress ----
    drv0(1'b1, 1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0);
    drv0(1'b1, 1'b0, 1'b0);
    drv0(1'b1, 1'b1, 1'b0);
    v0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv0(1'b1, 1'b0, 1'b0);
    chk("rst_mid_out", out0, 0);

    // ---- test 5b: sync_clr coincident with final pattern bit ----
    drv0(1'b0, 1'b0, 1'b1);
    drv0(1'b1, 1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0);
    drv0(1'b1, 1'b0, 1'b0);
    drv0(1'b1, 1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b1);
    chk("clr_last_out", out0, 0);
    chk("clr_last_cnt", cnt0, 0);
    drv0(1'b0, 1'b0, 1'b0);
    chk("clr_last_after", out0, 0);

    // ---- test 4: PAT_LEN=4, all-zero pattern ----
    ov1 = OVL;
    v1 = 1'b1; b1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("zero_out_bit%0d", i), out1, 0);
    end
    tick();
    chk("zero_out_bit4", out1, 1);
    tick();
    chk("zero_out_bit5_ovl", out1, 1);
    ov1 = NOVL;
    tick();
    chk("zero_out_bit6_novl", out1, 1);
    tick();
    chk("zero_out_bit7", out1, 0);
    v1 = 1'b0;
    tick();
    chk("zero_idle", out1, 0);
    chk("zero_cnt", cnt1, 3 * c_CNT_ON);

    // ---- test 6: CNT_W=2 saturation over 5 matches ----
    ov2 = OVL;
    s17 = 17'b10010010010010010;
    e17 = 17'b00001001001001001;
    nm = 0;
    for (int i = 16; i >= 0; i--) begin
      v2 = 1'b1; b2 = s17[i];
      tick();
      chk($sformatf("sat_out_bit%0d", 17 - i), out2, e17[i]);
      if (e17[i]) begin
        nm++;
        ecnt = (nm >= 3) ? 2'd3 : 2'(nm);
        chk($sformatf("sat_cnt_m%0d", nm), cnt2, (c_CNT_ON != 0) ? ecnt : 2'd0);
      end
    end
    v2 = 1'b0; clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("sat_clr_cnt", cnt2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_param_seq_det
`default_nettype wire
